// File: rtl/evr_pulse_pkg.sv
`default_nettype none
// ============================================================================
// Module   : evr_pulse_pkg
// Brief    : Shared types and constants for the event pulse generator bank.
// Revision : 1.0
// ============================================================================
package evr_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    ACTIVE = 2'd2
  } pulse_state_e;

  localparam logic [1:0] CFG_CTRL = 2'd0;
  localparam logic [1:0] CFG_PRE  = 2'd1;
  localparam logic [1:0] CFG_DLY  = 2'd2;
  localparam logic [1:0] CFG_WID  = 2'd3;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_POL = 1;

endpackage
`default_nettype wire

// File: rtl/evr_pulse_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : evr_pulse_bank_if
// Brief    : Host register-file write port into the pulse generator bank.
// Revision : 1.0
// ============================================================================
interface evr_pulse_bank_if;
  logic        cfg_we;
  logic [3:0]  cfg_ch;
  logic [1:0]  cfg_field;
  logic [31:0] cfg_wdata;

  modport master (output cfg_we, cfg_ch, cfg_field, cfg_wdata);
  modport slave  (input  cfg_we, cfg_ch, cfg_field, cfg_wdata);
endinterface
`default_nettype wire

// File: rtl/evr_pulse_ch.sv
`default_nettype none
// ============================================================================
// Module   : evr_pulse_ch
// Brief    : One triggered delay/width pulse generator with prescaler.
//            Define PULSE_RETRIG_EN to let a trigger restart a busy channel.
// Revision : 1.0
// ============================================================================
module evr_pulse_ch
  import evr_pulse_pkg::*;
#(
  parameter int DLY_W = 32,
  parameter int WID_W = 16,
  parameter int PRE_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trig,
  input  logic        hw_set,
  input  logic        hw_rst,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_field,
  input  logic [31:0] cfg_wdata,
  output logic        pulse,
  output logic        busy
);

`ifdef PULSE_RETRIG_EN
  localparam bit c_RETRIG = 1'b1;
`else
  localparam bit c_RETRIG = 1'b0;
`endif

  logic [1:0]       r_ctrl;
  logic [PRE_W-1:0] r_pre;
  logic [DLY_W-1:0] r_delay;
  logic [WID_W-1:0] r_width;

  pulse_state_e     r_state, w_state_nxt;
  logic             r_level, w_level_nxt;
  logic [DLY_W-1:0] r_dcnt, w_dcnt_nxt;
  logic [WID_W-1:0] r_wcnt, w_wcnt_nxt;
  logic [PRE_W-1:0] r_pcnt, w_pcnt_nxt;
  logic [PRE_W-1:0] r_pre_w, w_pre_w_nxt;
  logic [PRE_W-1:0] w_pe_m1;
  logic             w_tick;
  logic             w_accept;
  logic             r_pulse;
  logic             r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl  <= '0;
      r_pre   <= '0;
      r_delay <= '0;
      r_width <= '0;
    end else if (cfg_we) begin
      case (cfg_field)
        CFG_CTRL: r_ctrl  <= cfg_wdata[1:0];
        CFG_PRE:  r_pre   <= cfg_wdata[PRE_W-1:0];
        CFG_DLY:  r_delay <= cfg_wdata[DLY_W-1:0];
        CFG_WID:  r_width <= cfg_wdata[WID_W-1:0];
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_level <= 1'b0;
      r_dcnt  <= '0;
      r_wcnt  <= '0;
      r_pcnt  <= '0;
      r_pre_w <= '0;
      r_pulse <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_level <= w_level_nxt;
      r_dcnt  <= w_dcnt_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_pcnt  <= w_pcnt_nxt;
      r_pre_w <= w_pre_w_nxt;
      r_pulse <= r_level ^ r_ctrl[CTRL_POL];
      r_busy  <= (r_state != IDLE);
    end
  end

  // Prescale of 0 behaves like 1: a tick on every clock.
  assign w_pe_m1  = (r_pre_w == '0) ? '0 : r_pre_w - PRE_W'(1);
  assign w_tick   = (r_pcnt == w_pe_m1);
  assign w_accept = trig && r_ctrl[CTRL_EN] && (r_width != '0) &&
                    ((r_state == IDLE) || c_RETRIG);

  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    w_dcnt_nxt  = r_dcnt;
    w_wcnt_nxt  = r_wcnt;
    w_pcnt_nxt  = r_pcnt;
    w_pre_w_nxt = r_pre_w;
    if (hw_rst || !r_ctrl[CTRL_EN]) begin
      w_state_nxt = IDLE;
      w_level_nxt = 1'b0;
    end else if (hw_set) begin
      w_state_nxt = IDLE;
      w_level_nxt = 1'b1;
    end else if (w_accept) begin
      w_pre_w_nxt = r_pre;
      w_dcnt_nxt  = r_delay;
      w_wcnt_nxt  = r_width;
      w_pcnt_nxt  = '0;
      if (r_delay == '0) begin
        w_state_nxt = ACTIVE;
        w_level_nxt = 1'b1;
      end else begin
        w_state_nxt = DELAY;
        if (r_state == ACTIVE) begin
          w_level_nxt = 1'b0;
        end
      end
    end else if (r_state != IDLE) begin
      w_pcnt_nxt = w_tick ? '0 : r_pcnt + PRE_W'(1);
      if (w_tick) begin
        // Leave each phase on the tick that would take its counter to zero.
        if (r_state == DELAY) begin
          if (r_dcnt <= DLY_W'(1)) begin
            w_dcnt_nxt  = '0;
            w_state_nxt = ACTIVE;
            w_level_nxt = 1'b1;
          end else begin
            w_dcnt_nxt = r_dcnt - DLY_W'(1);
          end
        end else begin
          if (r_wcnt <= WID_W'(1)) begin
            w_wcnt_nxt  = '0;
            w_state_nxt = IDLE;
            w_level_nxt = 1'b0;
          end else begin
            w_wcnt_nxt = r_wcnt - WID_W'(1);
          end
        end
      end
    end
  end

  assign pulse = r_pulse;
  assign busy  = r_busy;

endmodule
`default_nettype wire

// File: rtl/evr_pulse_bank.sv
`default_nettype none
// ============================================================================
// Module   : evr_pulse_bank
// Brief    : Bank of NUM_PULSES event-triggered pulse generators with a shared
//            config write port. Define PULSE_RETRIG_EN for retriggering.
// Revision : 1.0
// ============================================================================
module evr_pulse_bank
  import evr_pulse_pkg::*;
#(
  parameter int NUM_PULSES = 14,
  parameter int DLY_W      = 32,
  parameter int WID_W      = 16,
  parameter int PRE_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_PULSES-1:0] trig,
  input  logic [NUM_PULSES-1:0] hw_set,
  input  logic [NUM_PULSES-1:0] hw_rst,
  evr_pulse_bank_if.slave       cfg,
  output logic [NUM_PULSES-1:0] pulses,
  output logic [NUM_PULSES-1:0] busy
);

  // Channel indices past NUM_PULSES never match, so those writes are dropped.
  for (genvar gi = 0; gi < NUM_PULSES; gi++) begin : g_ch
    localparam logic [3:0] c_IDX = 4'(gi);
    logic w_we;

    assign w_we = cfg.cfg_we && (cfg.cfg_ch == c_IDX);

    evr_pulse_ch #(
      .DLY_W (DLY_W),
      .WID_W (WID_W),
      .PRE_W (PRE_W)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .trig      (trig[gi]),
      .hw_set    (hw_set[gi]),
      .hw_rst    (hw_rst[gi]),
      .cfg_we    (w_we),
      .cfg_field (cfg.cfg_field),
      .cfg_wdata (cfg.cfg_wdata),
      .pulse     (pulses[gi]),
      .busy      (busy[gi])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_evr_pulse_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_evr_pulse_bank
// Brief    : Directed scoreboard bench for evr_pulse_bank.
// Revision : 1.0
// ============================================================================
module tb_evr_pulse_bank;
  import evr_pulse_pkg::*;

  localparam int NP = 14;

  typedef struct {
    int   cyc;
    int   ch;
    logic p;
    logic b;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [NP-1:0] trig;
  logic [NP-1:0] hw_set;
  logic [NP-1:0] hw_rst;
  logic [NP-1:0] pulses;
  logic [NP-1:0] busy;

  evr_pulse_bank_if bus ();

  evr_pulse_bank #(.NUM_PULSES(NP)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .trig   (trig),
    .hw_set (hw_set),
    .hw_rst (hw_rst),
    .cfg    (bus),
    .pulses (pulses),
    .busy   (busy)
  );

  exp_t  sb[$];
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_err = 0;
  bit    done = 1'b0;
  string tname = "reset";

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every queued expectation on the falling edge of its cycle.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_cmp++;
        if (pulses[e.ch] !== e.p || busy[e.ch] !== e.b) begin
          n_err++;
          $display("FAIL %s ch%0d cyc %0d: got pulses=%b busy=%b, want pulses=%b busy=%b",
                   tname, e.ch, cyc, pulses[e.ch], busy[e.ch], e.p, e.b);
        end
      end
      if (done) begin
        if (sb.size() != 0) begin
          n_err++;
          $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic cfg_write(input int ch, input int fld, input logic [31:0] d);
    bus.cfg_we    = 1'b1;
    bus.cfg_ch    = 4'(ch);
    bus.cfg_field = 2'(fld);
    bus.cfg_wdata = d;
    step();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic fire(input int ch);
    trig[ch] = 1'b1;
    step();
    trig[ch] = 1'b0;
  endtask

  // Expect pulse (XOR pol) high for offsets plo..phi and busy for blo..bhi.
  task automatic expect_win(input int ch, input int t0, input int n,
                            input int plo, input int phi,
                            input int blo, input int bhi, input logic pol);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.cyc = t0 + k;
      e.ch  = ch;
      e.p   = pol ^ ((k >= plo) && (k <= phi));
      e.b   = (k >= blo) && (k <= bhi);
      sb.push_back(e);
    end
  endtask

  task automatic expect_all_zero(input int c);
    for (int i = 0; i < NP; i++) expect_win(i, c, 1, 1, 0, 1, 0, 1'b0);
  endtask

  initial begin : stim
    int t;
    rst_n         = 1'b0;
    trig          = '0;
    hw_set        = '0;
    hw_rst        = '0;
    bus.cfg_we    = 1'b0;
    bus.cfg_ch    = '0;
    bus.cfg_field = '0;
    bus.cfg_wdata = '0;
    step(); step(); step();
    rst_n = 1'b1;
    expect_all_zero(cyc + 1);
    step(); step();

    tname = "ch0_basic";
    cfg_write(0, CFG_CTRL, 32'd1);
    cfg_write(0, CFG_DLY, 32'd5);
    cfg_write(0, CFG_WID, 32'd3);
    t = cyc + 1;
    expect_win(0, t, 11, 6, 8, 1, 8, 1'b0);
    fire(0);
    wait_until(t + 10);

    tname = "ch3_pre_pol";
    cfg_write(3, CFG_CTRL, 32'd3);
    cfg_write(3, CFG_PRE, 32'd4);
    cfg_write(3, CFG_DLY, 32'd2);
    cfg_write(3, CFG_WID, 32'd2);
    step(); step();
    t = cyc + 1;
    expect_win(3, t, 21, 9, 16, 1, 16, 1'b1);
    fire(3);
    wait_until(t + 20);

    tname = "ch1_retrig";
    cfg_write(1, CFG_CTRL, 32'd1);
    cfg_write(1, CFG_DLY, 32'd10);
    cfg_write(1, CFG_WID, 32'd4);
    t = cyc + 1;
`ifdef PULSE_RETRIG_EN
    expect_win(1, t, 21, 14, 17, 1, 17, 1'b0);
`else
    expect_win(1, t, 21, 11, 14, 1, 14, 1'b0);
`endif
    fire(1);
    step(); step();
    fire(1);
    wait_until(t + 20);

    tname = "ch2_hwrst_trig";
    cfg_write(2, CFG_CTRL, 32'd1);
    cfg_write(2, CFG_DLY, 32'd20);
    cfg_write(2, CFG_WID, 32'd5);
    t = cyc + 1;
    expect_win(2, t, 6, 1, 0, 1, 3, 1'b0);
    fire(2);
    step(); step();
    hw_rst[2] = 1'b1;
    trig[2]   = 1'b1;
    step();
    hw_rst[2] = 1'b0;
    trig[2]   = 1'b0;
    wait_until(t + 5);

    tname = "ch2_hwset_hold";
    t = cyc + 1;
    expect_win(2, t, 8, 1, 5, 1, 0, 1'b0);
    hw_set[2] = 1'b1;
    step();
    hw_set[2] = 1'b0;
    wait_until(t + 4);
    hw_rst[2] = 1'b1;
    step();
    hw_rst[2] = 1'b0;
    wait_until(t + 7);

    tname = "ch5_old_width";
    cfg_write(5, CFG_CTRL, 32'd1);
    cfg_write(5, CFG_DLY, 32'd20);
    cfg_write(5, CFG_WID, 32'd2);
    t = cyc + 1;
    expect_win(5, t, 26, 21, 22, 1, 22, 1'b0);
    fire(5);
    step();
    cfg_write(5, CFG_WID, 32'd9);
    wait_until(t + 25);
    cfg_write(15, CFG_CTRL, 32'd0);
    cfg_write(15, CFG_WID, 32'd1);

    tname = "ch5_new_width";
    t = cyc + 1;
    expect_win(5, t, 32, 21, 29, 1, 29, 1'b0);
    fire(5);
    wait_until(t + 31);

    tname = "ch4_width0";
    cfg_write(4, CFG_CTRL, 32'd1);
    t = cyc + 1;
    expect_win(4, t, 4, 1, 0, 1, 0, 1'b0);
    fire(4);
    wait_until(t + 3);

    tname = "ch6_disabled";
    cfg_write(6, CFG_WID, 32'd3);
    t = cyc + 1;
    expect_win(6, t, 4, 1, 0, 1, 0, 1'b0);
    fire(6);
    wait_until(t + 3);

    tname = "ch7_delay0";
    cfg_write(7, CFG_CTRL, 32'd1);
    cfg_write(7, CFG_WID, 32'd2);
    t = cyc + 1;
    expect_win(7, t, 5, 1, 2, 1, 2, 1'b0);
    fire(7);
    wait_until(t + 4);

    tname = "async_reset";
    t = cyc + 1;
    expect_win(0, t, 7, 6, 6, 1, 6, 1'b0);
    fire(0);
    wait_until(t + 7);
    expect_all_zero(cyc);
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;

    tname = "cfg_cleared";
    t = cyc + 1;
    expect_win(0, t, 10, 1, 0, 1, 0, 1'b0);
    fire(0);
    wait_until(t + 9);

    for (int i = 0; i < 100 && sb.size() > 0; i++) step();
    done = 1'b1;
  end

endmodule
`default_nettype wire

// File: doc/evr_pulse_bank.md
Name: evr_pulse_bank

Overview:
Bank of event-triggered pulse generators producing the 14-bit pulse vector consumed by the front-panel output mapper.
- Each channel waits for a one-cycle trigger strobe from the event decoder.
- It then counts a programmable delay and drives a pulse of programmable width, both scaled by a per-channel prescaler.
- Channels are configured through a simple register write port from the host register file.

Parameters:
NUM_PULSES, 14, number of generator channels (drives output width)
DLY_W, 32, delay counter width
WID_W, 16, width counter width
PRE_W, 16, prescaler counter width

Ports:
clk  input  1  system/event clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
trig  input  NUM_PULSES  one-cycle trigger strobes, one per channel
hw_set  input  NUM_PULSES  per-channel force-high strobe
hw_rst  input  NUM_PULSES  per-channel force-low / abort strobe
cfg_we  input  1  config write strobe
cfg_ch  input  4  target channel index; writes to index >= NUM_PULSES ignored
cfg_field  input  2  0=ctrl, 1=prescaler, 2=delay, 3=width
cfg_wdata  input  32  write data, LSB-aligned, truncated to field width
pulses  output  NUM_PULSES  registered pulse outputs
busy  output  NUM_PULSES  channel in DELAY or ACTIVE state

Behaviour:
- Reset (async assert, sync release):
  - all outputs 0, all states IDLE
  - ctrl=0, prescaler=0, delay=0, width=0
- ctrl bits: [0] enable, [1] polarity (1 = active-low output).
- Output: pulses[i] = level[i] XOR polarity[i], registered; enable=0 forces level=0, state IDLE.
- Config write: takes effect on the clock edge after cfg_we.
  - Working copies of prescaler/delay/width are latched at trigger acceptance.
  - Writes during DELAY/ACTIVE do not affect the pulse in flight.
- Effective prescale Pe = max(prescaler,1). A tick occurs every Pe clocks; the prescale counter restarts at trigger acceptance.
- States per channel:
  - IDLE: trig[i]=1 and enable -> latch copies.
    - delay=0 -> go to ACTIVE
    - otherwise -> go to DELAY
    - width=0 -> stay IDLE, no pulse
  - DELAY: decrement on each tick; on reaching 0 -> ACTIVE.
  - ACTIVE: level=1; decrement width on each tick; on reaching 0 -> level=0, go to IDLE.
- Latency: trigger sampled at edge T -> pulses rises at edge T+1+D*Pe and stays asserted exactly W*Pe cycles.
- busy[i]=1 in DELAY and ACTIVE.
- trig while DELAY/ACTIVE: ignored (see optional feature).
- hw_rst[i]: next edge level=0, state IDLE, aborts any pulse in flight.
- hw_set[i]: next edge level=1, state IDLE; level holds until a hw_rst or a completed triggered pulse clears it.
- Simultaneous events:
  - hw_rst wins over hw_set and trig
  - hw_set wins over trig
  - config write coincident with trig: trig latches the old value
- Counters never wrap: a channel does not decrement below 0, and the maximum delay is (2^DLY_W-1)*Pe cycles.
- Async reset mid-pulse: outputs drop to 0 immediately.

Optional Feature:
PULSE_RETRIG_EN
- Defined: trig in DELAY or ACTIVE reloads the working copies and restarts DELAY, with the prescale counter cleared. If delay=0, the channel stays in ACTIVE with width reloaded, so the pulse extends without a gap.
- Undefined: retrigger while busy is ignored, as above.

Decomposition:
- Package evr_pulse_pkg holds:
  - state enum (IDLE, DELAY, ACTIVE)
  - cfg_field constants (CFG_CTRL=0, CFG_PRE=1, CFG_DLY=2, CFG_WID=3)
  - ctrl bit index constants
- Sub-module evr_pulse_ch implements one channel:
  - config registers, FSM, prescale, delay and width counters
  - instantiated NUM_PULSES times by a generate loop
- Top level decodes cfg_ch/cfg_we and fans out the per-channel strobes.

Test Plan:
- ch0: enable=1, pre=0, delay=5, width=3; trig[0] at edge T -> pulses[0] high at edges T+6..T+8, low at T+9; busy[0] high T+1..T+8.
- ch3: pre=4, delay=2, width=2, polarity=1; trig -> pulses[3] low for 8 cycles starting at T+9, otherwise high.
- ch1: delay=10, width=4. Second trig at T+3 -> ignored, single pulse (macro off); with PULSE_RETRIG_EN -> pulse starts at T+14.
- ch2: busy in DELAY; hw_rst and trig at the same edge -> output stays 0, busy=0. Then hw_set -> pulses[2]=1 held; later hw_rst -> 0.
- ch5: delay=20; trig, then cfg write width=9 during DELAY -> pulse uses old width; next trig uses width 9. Write to cfg_ch=15 changes nothing.
- width=0 or enable=0 -> trig produces no pulse, busy stays 0. rst_n asserted mid-pulse -> all pulses 0 immediately and config cleared.
